// File: rtl/stage2_pkg.sv
// Shared encodings for the stage-2 decoder: instruction field positions,
// op/funct codes and the registered output bundle.
package stage2_pkg;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int IMM_MSB   = 15;
    localparam int FUNCT_MSB = 5;
    localparam int TGT_MSB   = 25;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LDW   = 6'h01;
    localparam logic [5:0] OP_STW   = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h04;
    localparam logic [5:0] OP_SUBI  = 6'h05;
    localparam logic [5:0] OP_MULI  = 6'h06;
    localparam logic [5:0] OP_DIVI  = 6'h07;
    localparam logic [5:0] OP_ANDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h09;
    localparam logic [5:0] OP_NORI  = 6'h0A;
    localparam logic [5:0] OP_XORI  = 6'h0B;
    localparam logic [5:0] OP_BEQ   = 6'h0C;
    localparam logic [5:0] OP_BNE   = 6'h0D;
    localparam logic [5:0] OP_BGT   = 6'h0E;
    localparam logic [5:0] OP_BLE   = 6'h0F;
    localparam logic [5:0] OP_ADDHI = 6'h24;
    localparam logic [5:0] OP_SUBHI = 6'h25;
    localparam logic [5:0] OP_MULHI = 6'h26;
    localparam logic [5:0] OP_DIVHI = 6'h27;
    localparam logic [5:0] OP_ANDHI = 6'h28;
    localparam logic [5:0] OP_ORHI  = 6'h29;
    localparam logic [5:0] OP_NORHI = 6'h2A;
    localparam logic [5:0] OP_XORHI = 6'h2B;
    localparam logic [5:0] OP_JMP   = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h04;
    localparam logic [5:0] FN_SUB = 6'h05;
    localparam logic [5:0] FN_MUL = 6'h06;
    localparam logic [5:0] FN_DIV = 6'h07;
    localparam logic [5:0] FN_AND = 6'h08;
    localparam logic [5:0] FN_OR  = 6'h09;
    localparam logic [5:0] FN_NOR = 6'h0A;
    localparam logic [5:0] FN_XOR = 6'h0B;
    localparam logic [5:0] FN_SLL = 6'h18;
    localparam logic [5:0] FN_SRL = 6'h19;
    localparam logic [5:0] FN_SLA = 6'h1A;
    localparam logic [5:0] FN_SRA = 6'h1B;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [5:0]  opcode;
        logic [4:0]  awr;
        logic        ewr;
        logic        jmp;
        logic        mrd;
        logic        mwr;
    } stage2_out_t;

    function automatic logic is_alu_funct(input logic [5:0] f);
        case (f)
            FN_ADD, FN_SUB, FN_MUL, FN_DIV,
            FN_AND, FN_OR,  FN_NOR, FN_XOR,
            FN_SLL, FN_SRL, FN_SLA, FN_SRA: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/stage2_regfile.sv
// 32x32 register file: two combinational read ports, one write port, r0 fixed
// at zero; a same-edge write is bypassed onto the read ports.
module stage2_regfile
    import stage2_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0][31:0] regs_q;
    logic [31:0][31:0] regs_d;
    logic              wr_en;

    // Gating on waddr here keeps r0 both unwritten and out of the bypass path.
    assign wr_en = we && (waddr != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[waddr] = wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) regs_q <= '0;
        else     regs_q <= regs_d;
    end

    always_comb begin
        rdata_a = regs_q[raddr_a];
        rdata_b = regs_q[raddr_b];
        if (wr_en && (waddr == raddr_a)) rdata_a = wdata;
        if (wr_en && (waddr == raddr_b)) rdata_b = wdata;
    end

endmodule

// File: rtl/stage2.sv
// Decode stage: splits the instruction, reads operands and registers the
// ALU/memory/branch control bundle when En_Pipeline is high.
module stage2
    import stage2_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        En_Pipeline,
    input  logic [31:0] instruction,
    input  logic [31:0] STG25_data_in,
    input  logic [4:0]  STG25_addr_Write_Reg,
    input  logic        STG25_En_Write_Reg,
    output logic [31:0] ALU_operand1,
    output logic [31:0] ALU_operand2,
    output logic [5:0]  opcode,
    output logic [4:0]  Addr_Write_Reg,
    output logic        En_Write_Reg,
    output logic        JMP_BR_flag,
    output logic        Mem_Read,
    output logic        Mem_Write
);

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [5:0]  funct;
    logic [25:0] target;
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    stage2_out_t dec;
    stage2_out_t pipe_d;
    stage2_out_t pipe_q;

    assign op     = instruction[OP_MSB:OP_LSB];
    assign rs     = instruction[RS_MSB:RS_LSB];
    assign rt     = instruction[RT_MSB:RT_LSB];
    assign rd     = instruction[RD_MSB:RD_LSB];
    assign imm    = instruction[IMM_MSB:0];
    assign funct  = instruction[FUNCT_MSB:0];
    assign target = instruction[TGT_MSB:0];

    stage2_regfile u_regfile (
        .clk     (clk),
        .rst     (reset),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rs_val),
        .rdata_b (rt_val),
        .we      (STG25_En_Write_Reg),
        .waddr   (STG25_addr_Write_Reg),
        .wdata   (STG25_data_in)
    );

    always_comb begin
        dec = '0;
        case (op)
            OP_RTYPE: begin
                if (is_alu_funct(funct)) begin
                    dec.opcode = funct;
                    dec.op1    = rs_val;
                    dec.op2    = rt_val;
                    dec.awr    = rd;
                    dec.ewr    = 1'b1;
                end
            end
            OP_ADDI, OP_SUBI, OP_MULI, OP_DIVI: begin
                dec.opcode = op;
                dec.op1    = rs_val;
                dec.op2    = {{16{imm[15]}}, imm};
                dec.awr    = rt;
                dec.ewr    = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_NORI, OP_XORI: begin
                dec.opcode = op;
                dec.op1    = rs_val;
                dec.op2    = {16'h0000, imm};
                dec.awr    = rt;
                dec.ewr    = 1'b1;
            end
            // High-immediate forms reuse the low-immediate ALU codes.
            OP_ADDHI, OP_SUBHI, OP_MULHI, OP_DIVHI,
            OP_ANDHI, OP_ORHI,  OP_NORHI, OP_XORHI: begin
                dec.opcode = {1'b0, op[4:0]};
                dec.op1    = rs_val;
                dec.op2    = {imm, 16'h0000};
                dec.awr    = rt;
                dec.ewr    = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BGT, OP_BLE: begin
                dec.opcode = op;
                dec.op1    = rs_val;
                dec.op2    = rt_val;
                dec.jmp    = 1'b1;
            end
            OP_LDW: begin
                dec.opcode = op;
                dec.op1    = rs_val;
                dec.op2    = {16'h0000, imm};
                dec.awr    = rt;
                dec.ewr    = 1'b1;
                dec.mrd    = 1'b1;
            end
            OP_STW: begin
                dec.opcode = op;
                dec.op1    = rt_val;
                dec.op2    = {16'h0000, imm};
                dec.mwr    = 1'b1;
            end
            OP_JMP: begin
                dec.opcode = op;
                dec.op2    = {6'd0, target};
                dec.jmp    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        pipe_d = pipe_q;
        if (En_Pipeline) pipe_d = dec;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pipe_q <= '0;
        else       pipe_q <= pipe_d;
    end

    assign ALU_operand1   = pipe_q.op1;
    assign ALU_operand2   = pipe_q.op2;
    assign opcode         = pipe_q.opcode;
    assign Addr_Write_Reg = pipe_q.awr;
    assign En_Write_Reg   = pipe_q.ewr;
    assign JMP_BR_flag    = pipe_q.jmp;
    assign Mem_Read       = pipe_q.mrd;
    assign Mem_Write      = pipe_q.mwr;

endmodule

// File: tb/tb_stage2.sv
// Directed vectors for stage2; expectations are queued at issue time and
// compared by an independent monitor on the falling edge.
module tb_stage2;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [31:0] instr;
    logic [31:0] wd;
    logic [4:0]  wa;
    logic        we;

    logic [31:0] op1, op2;
    logic [5:0]  opc;
    logic [4:0]  awr;
    logic        ewr, jmp, mr, mw;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [5:0]  opc;
        logic [4:0]  awr;
        logic        ewr;
        logic        jmp;
        logic        mr;
        logic        mw;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;
    exp_t  act;

    always #5 clk = ~clk;

    stage2 dut (
        .clk                  (clk),
        .reset                (reset),
        .En_Pipeline          (en),
        .instruction          (instr),
        .STG25_data_in        (wd),
        .STG25_addr_Write_Reg (wa),
        .STG25_En_Write_Reg   (we),
        .ALU_operand1         (op1),
        .ALU_operand2         (op2),
        .opcode               (opc),
        .Addr_Write_Reg       (awr),
        .En_Write_Reg         (ewr),
        .JMP_BR_flag          (jmp),
        .Mem_Read             (mr),
        .Mem_Write            (mw)
    );

    assign act = {op1, op2, opc, awr, ewr, jmp, mr, mw};

    function automatic exp_t mk(input logic [31:0] o1, input logic [31:0] o2,
                                input logic [5:0] oc, input logic [4:0] a,
                                input logic e, input logic j,
                                input logic r, input logic w);
        exp_t x;
        x = {o1, o2, oc, a, e, j, r, w};
        return x;
    endfunction

    task automatic issue(input string nm, input logic [31:0] i, input logic e_pl,
                         input logic w, input logic [4:0] a, input logic [31:0] d,
                         input exp_t x);
        @(negedge clk);
        instr = i; en = e_pl; we = w; wa = a; wd = d;
        @(posedge clk);
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    // Monitor: one pop per falling edge while expectations are pending.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL %s: got op1=%h op2=%h opc=%h awr=%0d ewr=%b jmp=%b mr=%b mw=%b, want op1=%h op2=%h opc=%h awr=%0d ewr=%b jmp=%b mr=%b mw=%b",
                             n, act.op1, act.op2, act.opc, act.awr, act.ewr, act.jmp, act.mr, act.mw,
                             e.op1, e.op2, e.opc, e.awr, e.ewr, e.jmp, e.mr, e.mw);
                end
            end
        end
    end

    initial begin
        exp_t z;
        exp_t hi;
        z  = mk(32'h0, 32'h0, 6'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        hi = mk(32'h7, 32'h12340000, 6'h0B, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);

        reset = 1'b1; en = 1'b0; instr = '0; we = 1'b0; wa = '0; wd = '0;
        #1;
        exp_q.push_back(z);
        name_q.push_back("reset_state");
        @(negedge clk); #1;
        reset = 1'b0;

        issue("wr_r2",    32'h00000000, 1'b1, 1'b1, 5'd2, 32'd2, z);
        issue("wr_r3",    32'h00000000, 1'b1, 1'b1, 5'd3, 32'd3, z);
        issue("add",      32'h00221804, 1'b1, 1'b0, 5'd0, 32'd0, mk(32'h0, 32'h2, 6'h04, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0));
        issue("addhi",    32'h90220005, 1'b1, 1'b0, 5'd0, 32'd0, mk(32'h0, 32'h00050000, 6'h04, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        issue("addi",     32'h10220005, 1'b1, 1'b0, 5'd0, 32'd0, mk(32'h0, 32'h5, 6'h04, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        issue("addi_neg", 32'h1022FFFF, 1'b1, 1'b0, 5'd0, 32'd0, mk(32'h0, 32'hFFFFFFFF, 6'h04, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        issue("andi",     32'h2022FFFF, 1'b1, 1'b0, 5'd0, 32'd0, mk(32'h0, 32'h0000FFFF, 6'h08, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        issue("beq",      32'h30430005, 1'b1, 1'b0, 5'd0, 32'd0, mk(32'h2, 32'h3, 6'h0C, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        issue("ble",      32'h3C430005, 1'b1, 1'b0, 5'd0, 32'd0, mk(32'h2, 32'h3, 6'h0F, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        issue("ldw",      32'h04430005, 1'b1, 1'b0, 5'd0, 32'd0, mk(32'h2, 32'h5, 6'h01, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0));
        issue("stw",      32'h08430005, 1'b1, 1'b0, 5'd0, 32'd0, mk(32'h3, 32'h5, 6'h02, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        issue("jmp",      32'hFC000005, 1'b1, 1'b0, 5'd0, 32'd0, mk(32'h0, 32'h5, 6'h3F, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        issue("fwd_beq",  32'h30430005, 1'b1, 1'b1, 5'd2, 32'd7, mk(32'h7, 32'h3, 6'h0C, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        issue("beq_r2_7", 32'h30430005, 1'b1, 1'b0, 5'd0, 32'd0, mk(32'h7, 32'h3, 6'h0C, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        issue("wr_r0",    32'h00032004, 1'b1, 1'b1, 5'd0, 32'hDEAD, mk(32'h0, 32'h3, 6'h04, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0));
        issue("rd_r0",    32'h00032004, 1'b1, 1'b0, 5'd0, 32'd0, mk(32'h0, 32'h3, 6'h04, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0));
        issue("bad_fn",   32'h00221803, 1'b1, 1'b0, 5'd0, 32'd0, z);
        issue("zero_ins", 32'h00000000, 1'b1, 1'b0, 5'd0, 32'd0, z);
        issue("bad_op",   32'hB0220005, 1'b1, 1'b0, 5'd0, 32'd0, z);
        issue("sra",      32'h0043281B, 1'b1, 1'b0, 5'd0, 32'd0, mk(32'h7, 32'h3, 6'h1B, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0));
        issue("xorhi",    32'hAC441234, 1'b1, 1'b0, 5'd0, 32'd0, hi);
        issue("hold",     32'h00221804, 1'b0, 1'b1, 5'd5, 32'h55, hi);
        issue("rd_r5",    32'h00A02804, 1'b1, 1'b0, 5'd0, 32'd0, mk(32'h55, 32'h0, 6'h04, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0));

        // Reset asserted mid-cycle, with a write-back that must be dropped.
        @(negedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'h99; instr = 32'h30430005;
        exp_q.push_back(z);
        name_q.push_back("rst_async");
        @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b0; we = 1'b0;

        issue("post_rst", 32'h30430005, 1'b1, 1'b0, 5'd0, 32'd0, mk(32'h0, 32'h0, 6'h0C, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stage2.md
STAGE2 -- requirements
Module: stage2

Interface
REQ-001 SHALL have: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high; clears all state.
REQ-003 SHALL have: En_Pipeline  in  1  1 = load output pipeline register; 0 = hold it.
REQ-004 SHALL have: instruction  in  32  fetched instruction.
REQ-005 SHALL have: STG25_data_in  in  32  write-back data.
REQ-006 SHALL have: STG25_addr_Write_Reg  in  5  write-back register index.
REQ-007 SHALL have: STG25_En_Write_Reg  in  1  write-back enable.
REQ-008 SHALL have outputs, all registered: ALU_operand1 (32), ALU_operand2 (32), opcode (6, ALU/operation code), Addr_Write_Reg (5), En_Write_Reg (1), JMP_BR_flag (1), Mem_Read (1), Mem_Write (1).

Function
REQ-009 Fields SHALL be: op[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0], funct[5:0], target[25:0].
REQ-010 Register file SHALL be 32x32 with combinational reads; r0 SHALL read 0 and ignore writes.
REQ-011 On a rising edge with STG25_En_Write_Reg=1 and addr≠0, the register file SHALL write STG25_data_in; the write is independent of En_Pipeline.
REQ-012 A same-edge write to a register being read SHALL be forwarded: the new data is captured.
REQ-013 All outputs SHALL update one edge after instruction is presented, when En_Pipeline=1.
REQ-014 R-type (op=0x00), funct 04 add, 05 sub, 06 mul, 07 div, 08 and, 09 or, 0A nor, 0B xor, 18 sll, 19 srl, 1A sla, 1B sra:
- opcode=funct, op1=R[rs], op2=R[rt]
- Addr_Write_Reg=rd, En_Write_Reg=1
REQ-015 Low-immediate I-type, op 04-07 (addi/subi/muli/divi) and 08-0B (andi/ori/nori/xori):
- opcode=op, op1=R[rs]
- op2=sign-extended imm for 04-07, zero-extended imm for 08-0B
- Addr_Write_Reg=rt, En_Write_Reg=1
REQ-016 High-immediate I-type, op 24-27 (addhi..divhi) and 28-2B (andhi..xorhi):
- opcode=op with bit5 cleared (04-0B), op1=R[rs], op2={imm,16'h0000}
- Addr_Write_Reg=rt, En_Write_Reg=1
REQ-017 Branches, op 0C beq, 0D bne, 0E bgt, 0F ble:
- opcode=op, op1=R[rs], op2=R[rt], JMP_BR_flag=1, En_Write_Reg=0
REQ-018 ldw, op 01:
- opcode=01, op1=R[rs], op2=zero-extended imm (address)
- Mem_Read=1, Addr_Write_Reg=rt, En_Write_Reg=1
REQ-019 stw, op 02:
- opcode=02, op1=R[rt] (store data), op2=zero-extended imm (address)
- Mem_Write=1, En_Write_Reg=0
REQ-020 jmp, op 3F:
- opcode=3F, op1=0, op2=zero-extended target, JMP_BR_flag=1, En_Write_Reg=0
REQ-021 Any other op, or R-type with an unlisted funct (including 0x00000000), SHALL be a NOP: all outputs 0.
REQ-022 Flags not named for an instruction SHALL be 0; Addr_Write_Reg SHALL be 0 whenever En_Write_Reg=0.
REQ-023 With En_Pipeline=0, outputs SHALL hold their previous values.

Reset
REQ-024 Reset SHALL immediately clear all outputs and all 32 registers to 0, regardless of clock.
REQ-025 A write-back coincident with reset assertion SHALL be discarded.
REQ-026 After reset deasserts, the first rising edge SHALL operate normally.

Structure
REQ-027 Package stage2_pkg SHALL hold the op/funct code constants and field bit positions.
REQ-028 The register file SHALL be sub-module stage2_regfile: two read ports, one write port, forwarding per REQ-012.
REQ-029 stage2 SHALL contain only the combinational decode and the output pipeline register.

Verification
REQ-030 Reset, write R2=2 and R3=3, apply 0x00221804 -> one edge later:
- op1=0, op2=2, opcode=04
- Addr_Write_Reg=3, En_Write_Reg=1
REQ-031 Apply 0x90220005 (addhi) -> opcode=04, op1=0, op2=0x00050000, Addr_Write_Reg=2; 0x10220005 (addi) -> op2=5.
REQ-032 Apply 0x30430005 (beq) -> op1=2, op2=3, opcode=0C, JMP_BR_flag=1, En_Write_Reg=0.
REQ-033 Memory and jump:
- 0x04430005 (ldw) -> Mem_Read=1, Addr_Write_Reg=3, op2=5
- 0x08430005 (stw) -> Mem_Write=1, op1=3
- 0xFC000005 (jmp) -> opcode=3F, op2=5, JMP_BR_flag=1
REQ-034 Forwarding and write rules:
- write R2=7 on the same edge beq 0x30430005 is captured -> op1=7
- write to R0 -> R0 still reads 0
REQ-035 Hold and reset:
- En_Pipeline=0 with a new instruction -> outputs unchanged
- reset pulse mid-stream -> all outputs and registers 0 immediately
